// File: rtl/dffram_arb_pkg.sv
// Shared constants and types for the two-master DFFRAM arbiter.
package dffram_arb_pkg;

  localparam int A_WIDTH    = 9;
  localparam int D_WIDTH    = 32;
  localparam int WE_WIDTH   = 4;
  localparam int LOCK_CNT_W = 8;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_t;

endpackage

// File: rtl/dffram_arb_core.sv
// Grant engine: round-robin between two masters, sticky lock for RMW
// sequences, and a watchdog that force-releases a lock held too long.
module dffram_arb_core
  import dffram_arb_pkg::*;
#(
  parameter int MAX_LOCK_CYCLES = 64
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] valid,
  input  logic [1:0] lock,
  output logic [1:0] grant,
  output logic       lock_abort
);

  localparam logic [LOCK_CNT_W-1:0] CNT_LAST = LOCK_CNT_W'(MAX_LOCK_CYCLES - 1);

  master_id_t            rr_ptr, rr_ptr_nxt;
  master_id_t            lock_owner, lock_owner_nxt;
  master_id_t            gnt_id;
  logic                  lock_active, lock_active_nxt;
  logic [LOCK_CNT_W-1:0] lock_cnt, lock_cnt_nxt;
  logic                  lock_req;
  logic                  wdog_hit;

  assign wdog_hit   = lock_active && (lock_cnt == CNT_LAST);
  assign lock_abort = wdog_hit;

  always_comb begin
    grant = 2'b00;
    if (!RST_N) begin
      grant = 2'b00;
    end else if (lock_active) begin
      // The non-owner stays blocked even while the owner is idle.
      grant = (lock_owner == M1) ? {valid[1], 1'b0} : {1'b0, valid[0]};
    end else if (&valid) begin
      grant = (rr_ptr == M1) ? 2'b10 : 2'b01;
    end else begin
      grant = valid;
    end
  end

  assign gnt_id   = grant[1] ? M1 : M0;
  assign lock_req = (gnt_id == M1) ? lock[1] : lock[0];

  always_comb begin
    rr_ptr_nxt      = rr_ptr;
    lock_owner_nxt  = lock_owner;
    lock_active_nxt = lock_active;
    lock_cnt_nxt    = lock_cnt;
    if (lock_active) begin
      // Watchdog wins over a continuing beat; that beat itself still completes.
      if (wdog_hit || ((|grant) && !lock_req)) begin
        lock_active_nxt = 1'b0;
        lock_cnt_nxt    = '0;
      end else begin
        lock_cnt_nxt = lock_cnt + 1'b1;
      end
    end else if (|grant) begin
      rr_ptr_nxt = (gnt_id == M1) ? M0 : M1;
      if (lock_req) begin
        lock_active_nxt = 1'b1;
        lock_owner_nxt  = gnt_id;
        lock_cnt_nxt    = '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_ptr      <= M0;
      lock_owner  <= M0;
      lock_active <= 1'b0;
      lock_cnt    <= '0;
    end else begin
      rr_ptr      <= rr_ptr_nxt;
      lock_owner  <= lock_owner_nxt;
      lock_active <= lock_active_nxt;
      lock_cnt    <= lock_cnt_nxt;
    end
  end

endmodule

// File: rtl/dffram_arbiter.sv
// Two-master arbiter in front of the single-port 512x32 DFFRAM.
// Optional per-master grant/stall counters: define DFFRAM_ARB_STATS_EN.
module dffram_arbiter #(
  parameter int A_WIDTH         = dffram_arb_pkg::A_WIDTH,
  parameter int D_WIDTH         = dffram_arb_pkg::D_WIDTH,
  parameter int MAX_LOCK_CYCLES = 64
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic                               m0_valid,
  output logic                               m0_ready,
  input  logic [dffram_arb_pkg::WE_WIDTH-1:0] m0_we,
  input  logic [A_WIDTH-1:0]                 m0_addr,
  input  logic [D_WIDTH-1:0]                 m0_wdata,
  input  logic                               m0_lock,
  output logic                               m0_rsp_valid,
  output logic [D_WIDTH-1:0]                 m0_rdata,
  input  logic                               m1_valid,
  output logic                               m1_ready,
  input  logic [dffram_arb_pkg::WE_WIDTH-1:0] m1_we,
  input  logic [A_WIDTH-1:0]                 m1_addr,
  input  logic [D_WIDTH-1:0]                 m1_wdata,
  input  logic                               m1_lock,
  output logic                               m1_rsp_valid,
  output logic [D_WIDTH-1:0]                 m1_rdata,
  output logic                               ram_en,
  output logic [dffram_arb_pkg::WE_WIDTH-1:0] ram_we,
  output logic [A_WIDTH-1:0]                 ram_a,
  output logic [D_WIDTH-1:0]                 ram_di,
  input  logic [D_WIDTH-1:0]                 ram_do,
  output logic                               lock_abort
`ifdef DFFRAM_ARB_STATS_EN
  ,
  output logic [15:0]                        m0_grant_cnt,
  output logic [15:0]                        m1_grant_cnt,
  output logic [15:0]                        m0_stall_cnt,
  output logic [15:0]                        m1_stall_cnt
`endif
);

  import dffram_arb_pkg::*;

  logic [1:0] grant;
  logic [1:0] vld_p1;

  dffram_arb_core #(
    .MAX_LOCK_CYCLES(MAX_LOCK_CYCLES)
  ) u_core (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .valid     ({m1_valid, m0_valid}),
    .lock      ({m1_lock, m0_lock}),
    .grant     (grant),
    .lock_abort(lock_abort)
  );

  assign m0_ready = grant[0];
  assign m1_ready = grant[1];

  // Stage p0: accepted beat drives the RAM pins directly
  assign ram_en = |grant;
  assign ram_we = grant[1] ? m1_we : (grant[0] ? m0_we : {WE_WIDTH{1'b0}});
  assign ram_a  = grant[1] ? m1_addr  : m0_addr;
  assign ram_di = grant[1] ? m1_wdata : m0_wdata;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) vld_p1 <= 2'b00;
    else        vld_p1 <= grant;
  end

  // Stage p1: RAM output is returned to whichever master was accepted
  assign m0_rsp_valid = vld_p1[0];
  assign m1_rsp_valid = vld_p1[1];
  assign m0_rdata     = vld_p1[0] ? ram_do : '0;
  assign m1_rdata     = vld_p1[1] ? ram_do : '0;

`ifdef DFFRAM_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic en);
    return (en && (cnt != 16'hFFFF)) ? cnt + 16'd1 : cnt;
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m0_grant_cnt <= '0;
      m1_grant_cnt <= '0;
      m0_stall_cnt <= '0;
      m1_stall_cnt <= '0;
    end else begin
      m0_grant_cnt <= sat_inc(m0_grant_cnt, grant[0]);
      m1_grant_cnt <= sat_inc(m1_grant_cnt, grant[1]);
      m0_stall_cnt <= sat_inc(m0_stall_cnt, m0_valid & ~grant[0]);
      m1_stall_cnt <= sat_inc(m1_stall_cnt, m1_valid & ~grant[1]);
    end
  end
`endif

endmodule

// File: tb/tb_dffram_arbiter.sv
// Randomized and directed bench for dffram_arbiter against a transaction-level model.
module tb_dffram_arbiter;

  localparam int MAXL = 8;

  logic        CLK;
  logic        RST_N;
  logic [1:0]  v, lk;
  logic [3:0]  we_d [2];
  logic [8:0]  ad   [2];
  logic [31:0] wd   [2];

  logic        m0_ready, m1_ready, m0_rsp_valid, m1_rsp_valid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [8:0]  ram_a;
  logic [31:0] ram_di;
  logic [31:0] ram_do;
  logic        lock_abort;
`ifdef DFFRAM_ARB_STATS_EN
  logic [15:0] m0_grant_cnt, m1_grant_cnt, m0_stall_cnt, m1_stall_cnt;
`endif

  dffram_arbiter #(.A_WIDTH(9), .D_WIDTH(32), .MAX_LOCK_CYCLES(MAXL)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .m0_valid(v[0]), .m0_ready(m0_ready), .m0_we(we_d[0]), .m0_addr(ad[0]),
    .m0_wdata(wd[0]), .m0_lock(lk[0]), .m0_rsp_valid(m0_rsp_valid), .m0_rdata(m0_rdata),
    .m1_valid(v[1]), .m1_ready(m1_ready), .m1_we(we_d[1]), .m1_addr(ad[1]),
    .m1_wdata(wd[1]), .m1_lock(lk[1]), .m1_rsp_valid(m1_rsp_valid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do),
    .lock_abort(lock_abort)
`ifdef DFFRAM_ARB_STATS_EN
    , .m0_grant_cnt(m0_grant_cnt), .m1_grant_cnt(m1_grant_cnt),
    .m0_stall_cnt(m0_stall_cnt), .m1_stall_cnt(m1_stall_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] init_word(input int i);
    return (i == 511) ? 32'h11223344 : ((32'(i) * 32'h01010101) ^ 32'hA5A50000);
  endfunction

  // Behavioural DFFRAM: registered read of the old word, byte-masked write.
  logic [31:0] mem [512];
  bit          mem_init = 1'b0;
  always @(posedge CLK) begin
    if (!mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (ram_en) begin
      ram_do <= mem[ram_a];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] mref [512];
  int          ptr, lk_who, lk_age, g_last;
  bit          lk_on;
  bit          pend_vld [2];
  logic [31:0] pend_data [2];

  task automatic model_reset();
    ptr = 0; lk_on = 0; lk_who = 0; lk_age = 0; g_last = -1;
    pend_vld[0] = 0; pend_vld[1] = 0;
  endtask

  task automatic cyc_check();
    int g;
    bit eab;
    @(negedge CLK);
    g = -1;
    eab = 0;
    if (!RST_N) begin
      model_reset();
    end else begin
      eab = lk_on && (lk_age == MAXL);
      if (lk_on)           g = v[lk_who] ? lk_who : -1;
      else if (v == 2'b11) g = ptr;
      else if (v[0])       g = 0;
      else if (v[1])       g = 1;
    end
    chk("m0_ready", m0_ready, g == 0);
    chk("m1_ready", m1_ready, g == 1);
    chk("ram_en", ram_en, g >= 0);
    if (g >= 0) begin
      chk("ram_we", ram_we, we_d[g]);
      chk("ram_a", ram_a, ad[g]);
      chk("ram_di", ram_di, wd[g]);
    end else begin
      chk("ram_we_idle", ram_we, 0);
    end
    chk("m0_rsp_valid", m0_rsp_valid, pend_vld[0]);
    chk("m1_rsp_valid", m1_rsp_valid, pend_vld[1]);
    chk("m0_rdata", m0_rdata, pend_vld[0] ? pend_data[0] : 32'h0);
    chk("m1_rdata", m1_rdata, pend_vld[1] ? pend_data[1] : 32'h0);
    chk("lock_abort", lock_abort, eab);
    if (!RST_N) return;
    pend_vld[0] = 0; pend_vld[1] = 0;
    if (g >= 0) begin
      pend_vld[g]  = 1;
      pend_data[g] = mref[ad[g]];
      for (int b = 0; b < 4; b++)
        if (we_d[g][b]) mref[ad[g]][8*b +: 8] = wd[g][8*b +: 8];
    end
    if (lk_on) begin
      if (lk_age == MAXL)                lk_on = 0;
      else if (g == lk_who && !lk[g])    lk_on = 0;
      else                               lk_age++;
    end else if (g >= 0) begin
      ptr = 1 - g;
      if (lk[g]) begin lk_on = 1; lk_who = g; lk_age = 1; end
    end
    g_last = g;
  endtask

  task automatic advance();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int n, input bit vv, input logic [3:0] w,
                         input logic [8:0] a, input logic [31:0] d, input bit l);
    v[n] = vv; we_d[n] = w; ad[n] = a; wd[n] = d; lk[n] = l;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mref[i] = init_word(i);
    model_reset();
    RST_N = 1'b0;
    v = 2'b00; lk = 2'b00;
    set_req(0, 1, 4'h0, 9'h010, 32'h0, 0);
    set_req(1, 1, 4'h0, 9'h010, 32'h0, 0);

    // Reset: ready/ram_en/rsp held low even with both masters valid
    cyc_check(); advance();
    cyc_check(); advance();
    RST_N = 1'b1;

    // Alternating grants, both reading 0x010
    for (int i = 0; i < 6; i++) begin
      cyc_check();
      chk("alt_m0_ready", m0_ready, (i % 2) == 0);
      if (i > 0) chk("alt_rsp_data", (i % 2 == 1) ? m0_rdata : m1_rdata, init_word(16));
      advance();
    end

    // Byte-masked write returns the pre-write word; next read sees the merge
    set_req(0, 0, 4'h0, 9'h000, 32'h0, 0);
    set_req(1, 1, 4'b0011, 9'h1FF, 32'hDEADBEEF, 0);
    cyc_check(); advance();
    set_req(1, 1, 4'h0, 9'h1FF, 32'h0, 0);
    cyc_check();
    chk("wr_old_word", m1_rdata, 32'h11223344);
    advance();
    set_req(1, 0, 4'h0, 9'h1FF, 32'h0, 0);
    cyc_check();
    chk("raw_new_word", m1_rdata, 32'h1122BEEF);
    advance();

    // Three-beat locked RMW by M0 while M1 waits
    set_req(1, 1, 4'h0, 9'h030, 32'h0, 0);
    for (int b = 0; b < 3; b++) begin
      set_req(0, 1, (b == 1) ? 4'hF : 4'h0, 9'h020, 32'hCAFE0001, b != 2);
      cyc_check();
      chk("lock_m0_ready", m0_ready, 1);
      chk("lock_m1_blocked", m1_ready, 0);
      advance();
    end
    set_req(0, 0, 4'h0, 9'h020, 32'h0, 0);
    cyc_check();
    chk("lock_release_m1", m1_ready, 1);
    chk("lock_rmw_data", m0_rdata, 32'hCAFE0001);
    advance();

    // Watchdog: M0 never releases
    set_req(0, 1, 4'h0, 9'h040, 32'h0, 1);
    set_req(1, 1, 4'h0, 9'h041, 32'h0, 0);
    for (int k = 0; k < 10; k++) begin
      cyc_check();
      chk("wd_abort", lock_abort, k == 8);
      chk("wd_m1_ready", m1_ready, k == 9);
      advance();
    end

    // Reset right after an accepted read
    set_req(0, 1, 4'h0, 9'h050, 32'h0, 0);
    set_req(1, 0, 4'h0, 9'h051, 32'h0, 0);
    cyc_check();
    RST_N = 1'b0;
    advance();
    v = 2'b11;
    cyc_check();
    chk("rst_rsp_dropped", m0_rsp_valid, 0);
    chk("rst_ram_en", ram_en, 0);
    advance();
    RST_N = 1'b1;
    cyc_check();
    chk("rst_m0_favoured", m0_ready, 1);
    advance();

    // Fresh reset, then 10 M0 grants with 3 M1 stall cycles
    RST_N = 1'b0;
    v = 2'b00;
    cyc_check(); advance();
    RST_N = 1'b1;
    for (int c = 0; c < 10; c++) begin
      set_req(0, 1, 4'h0, 9'(c), 32'h0, (c >= 6) && (c != 9));
      set_req(1, c >= 7, 4'h0, 9'h060, 32'h0, 0);
      cyc_check(); advance();
    end
    v = 2'b00;
    cyc_check();
`ifdef DFFRAM_ARB_STATS_EN
    chk("m0_grant_cnt", m0_grant_cnt, 10);
    chk("m1_stall_cnt", m1_stall_cnt, 3);
    chk("m1_grant_cnt", m1_grant_cnt, 0);
    chk("m0_stall_cnt", m0_stall_cnt, 0);
`endif
    advance();

    // Randomized traffic; a master holds its request until accepted
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (g_last == n || !v[n]) begin
          set_req(n, $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0,
                  9'($urandom_range(0, 15)), $urandom,
                  (lk_on && lk_who == n) ? ($urandom_range(0, 3) != 0)
                                         : ($urandom_range(0, 5) == 0));
        end
      end
      cyc_check();
      advance();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
